// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter: shares one combinational FP32 multiplier among NUM_REQ
// requesters using round-robin arbitration and a 2-stage valid/ready pipeline.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   req_valid[NUM_REQ]    per-requester request valid
//   req_a/req_b           operands, requester i at [32*i+31:32*i]
//   req_ready[NUM_REQ]    one-hot (or zero) accept to the arbitration winner
//   rsp_valid/rsp_ready   result handshake
//   rsp_data, rsp_id      FP32 product and the requester that issued it
//   op_count              completed response handshakes (wrapping)
//   idle                  no operation held in S1 or S2

// Truncating FP32 multiply without denormal/NaN/Inf handling.
// Negative exponent flushes to zero; exponent >= 256 saturates the magnitude.
module top_multiplier (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] p
);
  logic        sign;
  logic [47:0] prod;
  logic [24:0] prod_hi;
  logic [22:0] frac;
  logic [9:0]  exp_sum;

  always_comb begin
    sign    = a[31] ^ b[31];
    prod    = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    prod_hi = 25'(prod >> 23);
    // Product of two [1,2) mantissas lies in [1,4): shift by one when >= 2.
    frac    = prod_hi[24] ? prod_hi[23:1] : prod_hi[22:0];
    exp_sum = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127 + {9'd0, prod_hi[24]};
    if (a == 32'd0 || b == 32'd0 || exp_sum[9])
      p = 32'd0;
    else if (exp_sum[8])
      p = {sign, 31'h7FFF_FFFF};
    else
      p = {sign, exp_sum[7:0], frac};
  end
endmodule

module fp_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_data,
  output logic [ID_W-1:0]      rsp_id,
  output logic [CNT_W-1:0]     op_count,
  output logic                 idle
);
  logic [NUM_REQ-1:0][31:0] a_arr, b_arr;
  assign a_arr = req_a;
  assign b_arr = req_b;

  logic             s1_valid_q, s1_valid_d;
  logic [31:0]      s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [ID_W-1:0]  s1_id_q, s1_id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;

  logic             s2_adv, s1_adv, accept_en, handshake;
  logic             grant_found;
  logic [ID_W-1:0]  grant_id, arb_idx;
  logic [31:0]      mul_p;

  top_multiplier u_mul (
    .a (s1_a_q),
    .b (s1_b_q),
    .p (mul_p)
  );

  always_comb begin
    s2_adv    = !rsp_valid_q || rsp_ready;
    s1_adv    = s1_valid_q && s2_adv;
    accept_en = !s1_valid_q || s1_adv;

    // Round-robin search from the pointer; ID arithmetic wraps naturally
    // because NUM_REQ is a power of two.
    grant_found = 1'b0;
    grant_id    = '0;
    arb_idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      arb_idx = ptr_q + ID_W'(k);
      if (!grant_found && req_valid[arb_idx]) begin
        grant_found = 1'b1;
        grant_id    = arb_idx;
      end
    end

    handshake = accept_en && grant_found && !rst;
    req_ready = '0;
    if (handshake) req_ready[grant_id] = 1'b1;

    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_id_d     = s1_id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    ptr_d       = ptr_q;

    if (handshake) begin
      s1_valid_d = 1'b1;
      s1_a_d     = a_arr[grant_id];
      s1_b_d     = b_arr[grant_id];
      s1_id_d    = grant_id;
      ptr_d      = grant_id + ID_W'(1);
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    // Data/id only change when S2 reloads, so they stay frozen under stall.
    if (s1_adv) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = mul_p;
      rsp_id_d    = s1_id_q;
    end else if (s2_adv) begin
      rsp_valid_d = 1'b0;
    end

    op_count_d = op_count_q + CNT_W'(rsp_valid_q && rsp_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_id_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      op_count_q  <= '0;
      ptr_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_id_q     <= s1_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      op_count_q  <= op_count_d;
      ptr_q       <= ptr_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign op_count  = op_count_q;
  assign idle      = !s1_valid_q && !rsp_valid_q;
endmodule
